cpuclk_phase_tracker: RTL and testbench
=======================================

CPUCLK_PHASE_TRACKER -- requirements
Module: cpuclk_phase_tracker

Interface
REQ-001 SHALL have parameter LOCK_COUNT, default 8, meaning consecutive valid periods required to lock.
REQ-002 SHALL have parameter BAD_LIMIT, default 2, meaning consecutive invalid periods that drop lock.
REQ-003 SHALL have port clk28 input 1: the single clock, 28 MHz from the fabric clock divider; all logic in this domain.
REQ-004 SHALL have port reset input 1: synchronous, active-high reset.
REQ-005 SHALL have port cpuclk_a input 1: asynchronous Amiga 7 MHz CPU clock.
REQ-006 SHALL have port rise_stb output 1: one-cycle pulse per detected cpuclk_a rising edge.
REQ-007 SHALL have port fall_stb output 1: one-cycle pulse per detected falling edge.
REQ-008 SHALL have port phase output 3: clk28 cycles since last rise event, saturating at 7.
REQ-009 SHALL have port period output 4: last measured rise-to-rise period in clk28 cycles.
REQ-010 SHALL have port locked output 1: high while the state machine is LOCKED.
REQ-011 SHALL have port clk7_en output 1: rise_stb AND locked, registered alongside rise_stb.
REQ-012 SHALL have port lost output 1: one-cycle pulse on the LOCKED-to-UNLOCKED transition.

Function
REQ-013 SHALL synchronise cpuclk_a through flops s1, s2 and an edge flop s3 (s3 <= s2).
REQ-014 SHALL register rise_stb <= s2 & ~s3 and fall_stb <= ~s2 & s3; a rise stable before edge 0 gives rise_stb high for the cycle after edge 2.
REQ-015 SHALL define the rise event as s2 & ~s3, which is the same edge at which rise_stb is set.
REQ-016 SHALL on a rise event set phase to 0; otherwise increment phase, saturating at 7.
REQ-017 SHALL keep a 4-bit per_cnt, cleared on a rise event and otherwise incremented, saturating at 15.
REQ-018 SHALL on a rise event compute measured period = per_cnt + 1, load it into period, saturating at 15.
REQ-019 SHALL classify a measured period as valid iff it lies in 3..6 inclusive; the nominal value is 4, and 5 occurs from 28.57/7.09 MHz drift.
REQ-020 SHALL raise a timeout when per_cnt equals 15 with no rise event in that cycle.
REQ-021 SHALL implement states UNLOCKED, ACQUIRE and LOCKED, plus counters good_cnt and bad_cnt.
REQ-022 In UNLOCKED, a rise event SHALL move to ACQUIRE with good_cnt=0; that first period is not judged.
REQ-023 In ACQUIRE, a valid period SHALL increment good_cnt, moving to LOCKED when good_cnt reaches LOCK_COUNT.
REQ-024 In ACQUIRE, an invalid period SHALL clear good_cnt and stay in ACQUIRE; a timeout SHALL move to UNLOCKED.
REQ-025 In LOCKED, a valid period SHALL clear bad_cnt, and an invalid period SHALL increment bad_cnt.
REQ-026 In LOCKED, bad_cnt reaching BAD_LIMIT or a timeout SHALL move to UNLOCKED, assert lost for 1 cycle and clear good_cnt and bad_cnt.
REQ-027 If a rise event and per_cnt=15 coincide, the rise event SHALL take precedence: period=16 saturated to 15, invalid, and no timeout.
REQ-028 clk7_en SHALL be high only when rise_stb is high and the state before that edge was LOCKED; the 8th valid rise, which completes lock, SHALL NOT produce clk7_en.

Reset
REQ-029 Reset SHALL clear s1, s2, s3, phase, per_cnt, period, good_cnt, bad_cnt, rise_stb, fall_stb, clk7_en, locked and lost, and set state to UNLOCKED.
REQ-030 Reset asserted mid-operation SHALL take effect at the next clk28 edge, with no lost pulse generated.
REQ-031 If cpuclk_a is high at reset release, the resulting rise event SHALL only enter ACQUIRE, which is harmless.

Structure
REQ-032 Package cpuclk_pkg SHALL hold the state enum, PER_MIN=3, PER_MAX=6, TIMEOUT=15 and the default LOCK_COUNT and BAD_LIMIT.
REQ-033 Sub-module sync_edge SHALL contain s1, s2, s3 and the registered rise/fall strobes; everything else lives in the top.

Verification
REQ-034 Test 1: cpuclk_a period 4 clk28 cycles from reset -> first rise_stb 3 cycles after the first edge, locked high after 9th rise event, clk7_en from 10th, period=4.
REQ-035 Test 2: periods alternating 4,4,4,5 -> locked held, phase peaks 3 or 4, period tracks 4/5, lost never asserted.
REQ-036 Test 3: once locked, input stuck low -> lost pulse and locked low exactly 16 cycles after the last rise event.
REQ-037 Test 4: once locked, one period of 2 then 4s -> stays locked, bad_cnt cleared; two consecutive periods of 8 -> lost after second.
REQ-038 Test 5: in ACQUIRE after 5 valid periods, inject a period of 10 -> good_cnt resets, lock needs 8 further valid periods.
REQ-039 Test 6: reset pulse while LOCKED -> all outputs 0 next cycle, lost stays 0, and relock needs 9 rise events.

Source files
------------

// File: rtl/cpuclk_phase_tracker_pkg.sv
// Shared types and constants for the CPU clock phase tracker.
// Defines the lock-state encoding, the accepted period window and the period helpers.
`timescale 1ns/1ps
package cpuclk_pkg;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_e;

  localparam int PER_MIN        = 3;
  localparam int PER_MAX        = 6;
  localparam int TIMEOUT        = 15;
  localparam int DEF_LOCK_COUNT = 8;
  localparam int DEF_BAD_LIMIT  = 2;

  // Measured periods of 3..6 clk28 cycles count as a healthy 7 MHz clock.
  function automatic logic period_ok(input logic [4:0] meas);
    period_ok = (meas >= 5'(PER_MIN)) && (meas <= 5'(PER_MAX));
  endfunction

  function automatic logic [3:0] period_sat(input logic [4:0] meas);
    if (meas[4]) begin
      period_sat = 4'd15;
    end else begin
      period_sat = meas[3:0];
    end
  endfunction

endpackage

// File: rtl/cpuclk_phase_tracker_sync_edge.sv
// Two-flop synchroniser for the asynchronous CPU clock plus an edge flop.
// Exposes the combinational rise event and registered rise/fall strobes.
`timescale 1ns/1ps
module sync_edge (
  input  logic clk28,
  input  logic reset,
  input  logic async_in,
  output logic rise_ev,
  output logic rise_stb,
  output logic fall_stb
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // Next-state for the synchroniser chain and edge strobes.
  always_comb begin
    s1_d    = async_in;
    s2_d    = s1_q;
    s3_d    = s2_q;
    rise_ev = s2_q & ~s3_q;
    rise_d  = s2_q & ~s3_q;
    fall_d  = ~s2_q & s3_q;
  end

  // Synchroniser and strobe registers.
  always_ff @(posedge clk28) begin
    if (reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise_stb = rise_q;
  assign fall_stb = fall_q;

endmodule

// File: rtl/cpuclk_phase_tracker.sv
// Tracks the phase of the asynchronous 7 MHz Amiga CPU clock inside the 28 MHz domain,
// measures its period and maintains a lock state with a derived clk7 enable.
`timescale 1ns/1ps
module cpuclk_phase_tracker
  import cpuclk_pkg::*;
#(
  parameter int LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int BAD_LIMIT  = DEF_BAD_LIMIT
) (
  input  logic       clk28,
  input  logic       reset,
  input  logic       cpuclk_a,
  output logic       rise_stb,
  output logic       fall_stb,
  output logic [2:0] phase,
  output logic [3:0] period,
  output logic       locked,
  output logic       clk7_en,
  output logic       lost
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(BAD_LIMIT + 1);
  localparam logic [GW-1:0] GOOD_TARGET = GW'(LOCK_COUNT);
  localparam logic [BW-1:0] BAD_TARGET  = BW'(BAD_LIMIT);

  logic          rise_ev_s;
  logic [4:0]    meas_s;
  logic          meas_ok_s;
  logic          timeout_s;
  logic [GW-1:0] good_inc_s;
  logic [BW-1:0] bad_inc_s;

  state_e        state_q, state_d;
  logic [2:0]    phase_q, phase_d;
  logic [3:0]    per_cnt_q, per_cnt_d;
  logic [3:0]    period_q, period_d;
  logic [GW-1:0] good_cnt_q, good_cnt_d;
  logic [BW-1:0] bad_cnt_q, bad_cnt_d;
  logic          locked_q, locked_d;
  logic          clk7_en_q, clk7_en_d;
  logic          lost_q, lost_d;

  sync_edge u_sync (
    .clk28    (clk28),
    .reset    (reset),
    .async_in (cpuclk_a),
    .rise_ev  (rise_ev_s),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  // Phase, period measurement and timeout detection.
  always_comb begin
    meas_s    = {1'b0, per_cnt_q} + 5'd1;
    meas_ok_s = period_ok(meas_s);
    timeout_s = (per_cnt_q == 4'(TIMEOUT)) && !rise_ev_s;
    if (rise_ev_s) begin
      phase_d   = 3'd0;
      per_cnt_d = 4'd0;
      period_d  = period_sat(meas_s);
    end else begin
      phase_d   = (phase_q == 3'd7) ? phase_q : phase_q + 3'd1;
      per_cnt_d = (per_cnt_q == 4'd15) ? per_cnt_q : per_cnt_q + 4'd1;
      period_d  = period_q;
    end
  end

  // Lock state machine; a rise event always wins over a coinciding timeout.
  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    lost_d     = 1'b0;
    good_inc_s = good_cnt_q + GW'(1);
    bad_inc_s  = bad_cnt_q + BW'(1);
    case (state_q)
      ST_UNLOCKED: begin
        if (rise_ev_s) begin
          state_d    = ST_ACQUIRE;
          good_cnt_d = {GW{1'b0}};
          bad_cnt_d  = {BW{1'b0}};
        end else begin
          state_d = ST_UNLOCKED;
        end
      end
      ST_ACQUIRE: begin
        if (rise_ev_s) begin
          if (meas_ok_s) begin
            good_cnt_d = good_inc_s;
            if (good_inc_s == GOOD_TARGET) begin
              state_d   = ST_LOCKED;
              bad_cnt_d = {BW{1'b0}};
            end else begin
              state_d = ST_ACQUIRE;
            end
          end else begin
            good_cnt_d = {GW{1'b0}};
          end
        end else if (timeout_s) begin
          state_d    = ST_UNLOCKED;
          good_cnt_d = {GW{1'b0}};
          bad_cnt_d  = {BW{1'b0}};
        end else begin
          state_d = ST_ACQUIRE;
        end
      end
      ST_LOCKED: begin
        if (rise_ev_s) begin
          if (meas_ok_s) begin
            bad_cnt_d = {BW{1'b0}};
          end else if (bad_inc_s == BAD_TARGET) begin
            state_d    = ST_UNLOCKED;
            lost_d     = 1'b1;
            good_cnt_d = {GW{1'b0}};
            bad_cnt_d  = {BW{1'b0}};
          end else begin
            bad_cnt_d = bad_inc_s;
          end
        end else if (timeout_s) begin
          state_d    = ST_UNLOCKED;
          lost_d     = 1'b1;
          good_cnt_d = {GW{1'b0}};
          bad_cnt_d  = {BW{1'b0}};
        end else begin
          state_d = ST_LOCKED;
        end
      end
      default: begin
        state_d    = ST_UNLOCKED;
        good_cnt_d = {GW{1'b0}};
        bad_cnt_d  = {BW{1'b0}};
      end
    endcase
    locked_d  = (state_d == ST_LOCKED);
    clk7_en_d = rise_ev_s && (state_q == ST_LOCKED);
  end

  // State and output registers.
  always_ff @(posedge clk28) begin
    if (reset) begin
      state_q    <= ST_UNLOCKED;
      phase_q    <= 3'd0;
      per_cnt_q  <= 4'd0;
      period_q   <= 4'd0;
      good_cnt_q <= {GW{1'b0}};
      bad_cnt_q  <= {BW{1'b0}};
      locked_q   <= 1'b0;
      clk7_en_q  <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      per_cnt_q  <= per_cnt_d;
      period_q   <= period_d;
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
      locked_q   <= locked_d;
      clk7_en_q  <= clk7_en_d;
      lost_q     <= lost_d;
    end
  end

  assign phase   = phase_q;
  assign period  = period_q;
  assign locked  = locked_q;
  assign clk7_en = clk7_en_q;
  assign lost    = lost_q;

endmodule

// File: tb/tb_cpuclk_phase_tracker.sv
// Self-checking bench for cpuclk_phase_tracker: a reset table, directed lock/unlock
// sequences and random periods, all checked cycle by cycle against an event-level model.
`timescale 1ns/1ps
module tb_cpuclk_phase_tracker;

  localparam int LC = 8;
  localparam int BL = 2;
  localparam int M_IDLE = 0;
  localparam int M_ACQ  = 1;
  localparam int M_LOCK = 2;

  logic clk28 = 1'b0;
  logic reset = 1'b1;
  logic cpuclk_a = 1'b0;
  logic rise_stb, fall_stb, locked, clk7_en, lost;
  logic [2:0] phase;
  logic [3:0] period;

  cpuclk_phase_tracker #(.LOCK_COUNT(LC), .BAD_LIMIT(BL)) dut (
    .clk28    (clk28),
    .reset    (reset),
    .cpuclk_a (cpuclk_a),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb),
    .phase    (phase),
    .period   (period),
    .locked   (locked),
    .clk7_en  (clk7_en),
    .lost     (lost)
  );

  always #5 clk28 = ~clk28;

  int total = 0;
  int bad = 0;

  // Input value seen at each clk28 edge; a reset edge flushes the last three.
  bit hist [0:65535];
  int cyc = 3;

  int m_mode, m_good, m_bad, m_last;
  logic m_rise, m_fall, m_locked, m_clk7, m_lost;
  logic [2:0] m_phase;
  logic [3:0] m_period;

  bit saw_clk7, lost_seen;
  int max_phase, last_rise_cyc, lost_cyc;

  typedef struct {
    bit rst;
    bit a;
    bit e_rise;
    bit e_fall;
    int e_phase;
    int e_period;
    bit e_locked;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic model_step(input int n, input bit rst);
    int gap, meas;
    bit rise, fall, ok;
    if (rst) begin
      hist[n] = 1'b0; hist[n-1] = 1'b0; hist[n-2] = 1'b0;
      m_mode = M_IDLE; m_good = 0; m_bad = 0; m_last = n;
      m_rise = 1'b0; m_fall = 1'b0; m_locked = 1'b0; m_clk7 = 1'b0; m_lost = 1'b0;
      m_phase = 3'd0; m_period = 4'd0;
    end else begin
      rise = hist[n-2] && !hist[n-3];
      fall = !hist[n-2] && hist[n-3];
      gap = n - m_last;
      m_rise = rise;
      m_fall = fall;
      m_lost = 1'b0;
      m_clk7 = rise && (m_mode == M_LOCK);
      if (rise) begin
        meas = (gap > 16) ? 16 : gap;
        m_period = (meas > 15) ? 4'd15 : 4'(meas);
        ok = (meas >= 3) && (meas <= 6);
        if (m_mode == M_IDLE) begin
          m_mode = M_ACQ; m_good = 0;
        end else if (m_mode == M_ACQ) begin
          if (ok) begin
            m_good++;
            if (m_good == LC) begin m_mode = M_LOCK; m_bad = 0; end
          end else begin
            m_good = 0;
          end
        end else begin
          if (ok) begin
            m_bad = 0;
          end else begin
            m_bad++;
            if (m_bad == BL) begin m_mode = M_IDLE; m_lost = 1'b1; m_good = 0; m_bad = 0; end
          end
        end
        m_last = n;
      end else if (gap >= 16) begin
        if (m_mode == M_LOCK) m_lost = 1'b1;
        m_mode = M_IDLE; m_good = 0; m_bad = 0;
      end
      m_phase = ((n - m_last) > 7) ? 3'd7 : 3'(n - m_last);
      m_locked = (m_mode == M_LOCK);
    end
  endtask

  task automatic tick(input bit r, input bit a);
    logic [12:0] got, exp;
    reset = r;
    cpuclk_a = a;
    if (!r) hist[cyc] = a;
    model_step(cyc, r);
    @(posedge clk28);
    #1;
    got = {rise_stb, fall_stb, phase, period, locked, clk7_en, lost};
    exp = {m_rise, m_fall, m_phase, m_period, m_locked, m_clk7, m_lost};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL model cyc=%0d got=%h exp=%h (rise,fall,phase,period,locked,clk7,lost)", cyc, got, exp);
    end
    if (rise_stb) last_rise_cyc = cyc;
    if (lost) begin lost_cyc = cyc; lost_seen = 1'b1; end
    if (clk7_en) saw_clk7 = 1'b1;
    if (int'(phase) > max_phase) max_phase = int'(phase);
    cyc++;
  endtask

  task automatic drive_period(input int p, input int hi);
    saw_clk7 = 1'b0;
    for (int i = 0; i < p; i++) tick(1'b0, i < hi);
  endtask

  task automatic drive4(input int n);
    for (int i = 0; i < n; i++) drive_period(4, 2);
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 2, 0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 3, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 3, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 2, 3, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 3, 3, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 4, 3, 1'b0};

    // Reset and first edge timing from the table.
    for (int i = 0; i < 8; i++) begin
      tick(tbl[i].rst, tbl[i].a);
      chk("tbl_rise", rise_stb, tbl[i].e_rise);
      chk("tbl_fall", fall_stb, tbl[i].e_fall);
      chk("tbl_phase", phase, tbl[i].e_phase);
      chk("tbl_period", period, tbl[i].e_period);
      chk("tbl_locked", locked, tbl[i].e_locked);
    end

    // Test 1: lock after the 9th rise, clk7_en from the 10th.
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      drive4(1);
      chk("t1_locked", locked, k >= 9);
      chk("t1_clk7", saw_clk7, k >= 10);
    end
    chk("t1_period", period, 4);

    // Test 2: 4,4,4,5 drift keeps lock.
    lost_seen = 1'b0;
    max_phase = 0;
    for (int k = 0; k < 4; k++) begin
      drive4(3);
      drive_period(5, 2);
    end
    drive4(1);
    chk("t2_locked", locked, 1);
    chk("t2_lost", lost_seen, 0);
    chk("t2_maxphase", max_phase, 4);
    chk("t2_period", period, 5);

    // Test 3: stuck low drops lock 16 cycles after the last rise.
    lost_cyc = -1;
    for (int i = 0; i < 30; i++) tick(1'b0, 1'b0);
    chk("t3_gap", lost_cyc - last_rise_cyc, 16);
    chk("t3_locked", locked, 0);

    // Test 4: one short period tolerated, two long periods drop lock.
    drive4(9);
    chk("t4_relock", locked, 1);
    lost_seen = 1'b0;
    drive_period(2, 1);
    drive4(3);
    drive_period(2, 1);
    drive4(2);
    chk("t4_hold", locked, 1);
    chk("t4_nolost", lost_seen, 0);
    drive_period(8, 4);
    drive_period(8, 4);
    chk("t4_after_one8", locked, 1);
    drive4(1);
    chk("t4_dropped", locked, 0);
    chk("t4_lost", lost_seen, 1);

    // Test 5: an invalid period during acquire restarts the count.
    tick(1'b1, 1'b0);
    drive4(5);
    drive_period(10, 5);
    drive4(8);
    chk("t5_not_yet", locked, 0);
    drive4(1);
    chk("t5_locked", locked, 1);

    // Test 6: reset while locked clears everything without a lost pulse.
    tick(1'b1, 1'b0);
    chk("t6_outs", {rise_stb, fall_stb, phase, period, locked, clk7_en, lost}, 0);
    tick(1'b0, 1'b0);
    chk("t6_lost", lost, 0);
    drive4(8);
    chk("t6_not_yet", locked, 0);
    drive4(1);
    chk("t6_relocked", locked, 1);

    // Rise coinciding with a saturated period counter: period 16 -> 15, no timeout.
    tick(1'b1, 1'b0);
    drive4(3);
    drive_period(16, 8);
    drive4(1);
    chk("t7_period", period, 15);
    chk("t7_locked", locked, 0);

    // Random periods, duty cycles, long gaps and occasional resets.
    for (int k = 0; k < 300; k++) begin
      int p, hi;
      if ($urandom_range(0, 39) == 0) begin
        tick(1'b1, 1'($urandom_range(0, 1)));
      end else begin
        p = ($urandom_range(0, 14) == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(2, 9));
        hi = $urandom_range(1, p - 1);
        drive_period(p, hi);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
